// File: rtl/spi_ctrl_pkg.sv
// Shared widths, state encoding and helpers for the SPI request arbiter.
// Imported by the arbiter top and its round-robin picker.
package spi_ctrl_pkg;

  localparam int SPI_WIDTH_W     = 8;
  localparam int SPI_CMD_W       = 2;
  localparam int SPI_DATA_W      = 8;
  localparam int TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Position 'off' slots after 'base' on a ring of 'n' requesters.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo NUM_REQ. Outputs one-hot grant, its index and an any flag.
module rr_pick
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  function automatic logic [IDX_W-1:0] slot(input logic [IDX_W-1:0] ptr,
                                            input int unsigned       off);
    return IDX_W'(rr_wrap(32'(ptr), off, NUM_REQ));
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    idx_o = '0;
    any_o = 1'b0;
    // Scan farthest-first so the slot nearest the pointer overwrites the rest.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req_i[slot(ptr_i, off)]) begin
        idx_o = slot(ptr_i, off);
        any_o = 1'b1;
      end
    end
    gnt_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI_MO shift engine between NUM_REQ
// requesters: latch the winner's fields, pulse start, await completion or timeout.
module spi_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*SPI_WIDTH_W-1:0] req_width,
  input  logic [NUM_REQ*SPI_CMD_W-1:0]   req_cmd,
  input  logic [NUM_REQ*SPI_DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_grant,
  output logic [NUM_REQ-1:0]             req_done,
  output logic                           req_err,
  output logic                           spi_start,
  output logic [SPI_WIDTH_W-1:0]         spi_width,
  output logic [SPI_CMD_W-1:0]           spi_cmd,
  output logic [SPI_DATA_W-1:0]          spi_data,
  input  logic                           out_flag,
  output logic                           busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e             state_q;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]     owner_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_flag_q;
  logic                   flag_rise;

  logic [NUM_REQ-1:0]     grant_q, done_q;
  logic                   err_q, start_q;
  logic [SPI_WIDTH_W-1:0] width_q, sel_width;
  logic [SPI_CMD_W-1:0]   cmd_q, sel_cmd;
  logic [SPI_DATA_W-1:0]  data_q, sel_data;

  logic [NUM_REQ-1:0]     pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    sel_width = '0;
    sel_cmd   = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_width = req_width[i*SPI_WIDTH_W +: SPI_WIDTH_W];
        sel_cmd   = req_cmd[i*SPI_CMD_W +: SPI_CMD_W];
        sel_data  = req_data[i*SPI_DATA_W +: SPI_DATA_W];
      end
    end
  end

  assign rr_ptr_d  = IDX_W'(rr_wrap(32'(pick_idx), 1, NUM_REQ));
  assign cnt_d     = cnt_q + CNT_W'(1);
  // Only a fresh rising edge completes; a level left high from before WAIT does not.
  assign flag_rise = out_flag & ~out_flag_q;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      out_flag_q <= 1'b0;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      width_q    <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
    end else begin
      out_flag_q <= out_flag;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            width_q  <= sel_width;
            cmd_q    <= sel_cmd;
            data_q   <= sel_data;
            grant_q  <= pick_gnt;
            owner_q  <= pick_gnt;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          start_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_d;
          if (flag_rise) begin
            done_q  <= owner_q;
            state_q <= ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            done_q  <= owner_q;
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_grant = grant_q;
  assign req_done  = done_q;
  assign req_err   = err_q;
  assign spi_start = start_q;
  assign spi_width = width_q;
  assign spi_cmd   = cmd_q;
  assign spi_data  = data_q;
  assign busy      = (state_q != ST_IDLE);

  a_grant_onehot: assert property (@(posedge sys_clk) disable iff (sys_rst)
    $onehot0(req_grant));
  a_done_onehot: assert property (@(posedge sys_clk) disable iff (sys_rst)
    $onehot0(req_done));
  a_err_with_done: assert property (@(posedge sys_clk) disable iff (sys_rst)
    req_err |-> (req_done != '0));

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares one SPI_MO shift engine between NUM_REQ independent requesters, e.g. the HMC7044 power-up config fsm and a runtime register-write path.
- Round-robin arbitration; one SPI transfer in flight at a time.
- Latches the winner's width/cmd/data and pulses start to the shifter.
- Waits for the shifter's completion flag, or a timeout, then reports done/err to the winner.
- Sits between the requesters and SPI_MO, in the SCK_5MHz domain.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYC, 1024, sys_clk cycles allowed in WAIT before abort.

Ports:
- sys_clk  in  1  single clock (SCK_5MHz domain).
- sys_rst  in  1  reset.
- req_valid  in  NUM_REQ  per-requester request; hold high until its grant bit is seen.
- req_width  in  NUM_REQ*8  packed transfer widths; slice i = [8i+7:8i].
- req_cmd  in  NUM_REQ*2  packed commands.
- req_data  in  NUM_REQ*8  packed write data.
- req_grant  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted, fields latched.
- req_done  out  NUM_REQ  one-hot, 1-cycle pulse: transfer finished or aborted.
- req_err  out  1  1-cycle pulse coincident with req_done on timeout.
- spi_start  out  1  1-cycle start pulse to SPI_MO.
- spi_width  out  8  latched width to SPI_MO.
- spi_cmd  out  2  latched cmd to SPI_MO.
- spi_data  out  8  latched data to SPI_MO.
- out_flag  in  1  completion flag from SPI_MO; rising edge = transfer done.
- busy  out  1  high in every state other than IDLE.

Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (synchronous, active-high, at the next sys_clk edge): state=IDLE, rr_ptr=0, out_flag_d=0, timeout counter=0. All outputs 0: req_grant, req_done, req_err, spi_start, spi_width, spi_cmd, spi_data, busy. Reset asserted mid-transfer aborts it; no done is reported.
- States:
  - IDLE -> ISSUE
  - ISSUE -> WAIT
  - WAIT -> IDLE
- IDLE, at edge k with any req_valid set:
  - Pick g = first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Latch slice g of width/cmd/data into the spi_* registers.
  - req_grant[g]=1 during cycle k+1; rr_ptr <= (g+1) mod NUM_REQ.
  - Next state ISSUE.
- ISSUE: spi_start=1 for exactly one cycle (k+2). req_grant returns to 0. Counter cleared. Next state WAIT.
- WAIT:
  - req_valid is ignored.
  - Counter increments each cycle.
  - If out_flag=1 and out_flag_d=0: req_done[g]=1 for one cycle, req_err=0, next state IDLE.
  - Else if counter reaches TIMEOUT_CYC-1: req_done[g]=1 and req_err=1 for one cycle, next state IDLE.
  - If a rising edge and timeout expiry coincide, the edge wins (no err).
- Edge detection: out_flag_d is registered every cycle in all states. A level already high when entering WAIT does not complete the transfer; only a new rising edge does.
- Latency: grant follows req_valid by 1 cycle; start follows grant by 1 cycle.
- Minimum turnaround: a new grant can come 1 cycle after the req_done cycle (IDLE spends ≥1 cycle).
- spi_width/cmd/data stay stable from the latch until the next grant.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,...,NUM_REQ-1,0.
- A requester that drops req_valid before being granted is simply skipped.

Decomposition:
- Package spi_ctrl_pkg holds:
  - SPI_WIDTH_W=8, SPI_CMD_W=2, SPI_DATA_W=8.
  - State encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2.
  - Default TIMEOUT_CYC.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req[NUM_REQ], ptr.
  - Outputs: one-hot gnt, index, any.
- FSM, latches, counter and edge detect live in spi_arbiter.

Test Plan:
- Single request:
  - Stimulus: req_valid=2'b01, width=8'd24, cmd=2'b01, data=8'hA5; out_flag rises 40 cycles after start.
  - Response: grant[0] 1 cycle after req, spi_start 1 cycle after grant, spi_* = 24/01/A5, req_done[0] 1 cycle after the out_flag edge, req_err=0.
- Contention:
  - Stimulus: both requesters valid continuously for 4 transfers.
  - Response: grant order 0,1,0,1; each requester's data appears on spi_data in its own slot.
- Timeout:
  - Stimulus: TIMEOUT_CYC=16, out_flag held 0.
  - Response: req_done[g] and req_err pulse together exactly 16 cycles after spi_start; next request is accepted afterwards.
- Stale flag:
  - Stimulus: out_flag held 1 through ISSUE, falls, rises 10 cycles into WAIT.
  - Response: no done until the rise; done fires 1 cycle after it.
- Reset mid-WAIT:
  - Stimulus: assert sys_rst for 1 cycle during WAIT.
  - Response: next cycle busy=0, all outputs 0, no req_done; rr_ptr=0, so req0 wins the next tie.
- Coincident completion and timeout:
  - Stimulus: out_flag rising edge on the same cycle the counter reaches TIMEOUT_CYC-1.
  - Response: req_done pulses with req_err=0.
